logic_pipe_xnor_cmp: RTL and testbench
======================================

Name: logic_pipe_xnor_cmp

Overview:
- Parametrised, pipelined successor to the single-bit XNOR gate.
- Applies a selectable bitwise operation to two WIDTH-bit operands and counts the bit positions where the operands agree (XNOR popcount).
- Flags whole-word equality and keeps a saturating count of equal words.
- Sits between a producer and a consumer, with valid/ready handshakes on both sides. Used as the generic compare/logic element in later lab blocks.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
CNT_W, 16, width of the saturating equal-word counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer presents a transaction
in_ready  output  1  block accepts a transaction this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select, captured with the operands
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
y  output  WIDTH  bitwise result
match_cnt  output  clog2(WIDTH+1)  number of bit positions where a==b
all_eq  output  1  1 when a==b on every bit
eq_count  output  CNT_W  saturating count of delivered results with all_eq=1
clr  input  1  synchronous clear of eq_count

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All pipeline valids are 0.
  - y, match_cnt, all_eq and eq_count are 0.
  - in_ready is 1 once reset is released. It is combinational from the valids and out_ready.
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 XNOR.
  - 100 NAND, 101 NOR, 110 NOT a (b ignored), 111 pass a.
- match_cnt is popcount(~(a^b)) for every op; it does not depend on op.
- all_eq = (match_cnt == WIDTH).
- Pipeline, two register stages:
  - S1 registers y and the per-bit XNOR vector.
  - S2 registers y, match_cnt and all_eq.
  - Outputs come directly from S2.
- Handshake rules:
  - s2_load = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_load.
  - in_ready = s1_adv.
  - Input handshake (in_valid && in_ready) loads S1.
  - Output handshake (out_valid && out_ready) retires S2.
- Latency: exactly 2 cycles from input handshake to out_valid, with out_ready held high.
- Throughput: one transaction per cycle while out_ready=1.
- Backpressure:
  - While out_ready=0 and both stages are full, in_ready=0.
  - Data in S1 and S2 holds stable; no transaction is lost or duplicated.
  - y, match_cnt and all_eq must not change while out_valid=1 and out_ready=0.
- Bubbles: when S2 is empty, S1 moves forward regardless of out_ready.
- eq_count:
  - Increments by 1 on each output handshake where all_eq=1.
  - Saturates at 2^CNT_W-1.
  - clr=1 forces 0 on the next edge; clr wins over a simultaneous increment.
  - clr does not affect the pipeline.
- Reset mid-operation: in-flight transactions are discarded and all outputs return to reset values immediately.
- Inputs a, b and op are sampled only at the input handshake. Changes at other times have no effect.

Test Plan:
1. Reset then idle -> in_ready=1, out_valid=0, y=0, eq_count=0. Assert rst_n low for 2 cycles mid-stream -> out_valid drops asynchronously.
2. Op sweep, WIDTH=8, a=8'hA5, b=8'h0F, out_ready=1. For op 000..111 -> y = 05, AF, AA, 55, FA, 50, 5A, A5 after 2 cycles; match_cnt=4 and all_eq=0 on every op.
3. Back-to-back stream of 6 transactions with out_ready=1 -> 6 consecutive out_valid cycles, in order, no gaps.
4. Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles.
   - in_ready=0 after both stages are full.
   - Outputs stay stable.
   - After release, both held results appear in order, then the next one.
5. Equality counting with a=b=8'h3C repeated 3 times -> all_eq=1, match_cnt=8, eq_count=3. Pulse clr in the same cycle as a 4th equal handshake -> eq_count=0.
6. Saturation with CNT_W=2 -> 5 equal handshakes leave eq_count=3. A held result under out_ready=0 is counted only once.

Source files
------------

// File: rtl/logic_pipe_xnor_cmp.sv
// logic_pipe_xnor_cmp: 2-stage valid/ready pipe; y=op(a,b), match_cnt=popcount(a xnor b), all_eq, saturating eq_count (clr clears)
module logic_pipe_xnor_cmp #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic [2:0]                   op,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             y,
   output logic [$clog2(WIDTH+1)-1:0]   match_cnt,
   output logic                         all_eq,
   output logic [CNT_W-1:0]             eq_count,
   input  logic                         clr
);
   localparam int MW = $clog2(WIDTH+1);
   logic s1_valid, s2_valid, s2_load, s1_adv;
   logic [WIDTH-1:0] s1_y, s1_x, f_y;
   logic [MW-1:0] pc;
   assign s2_load   = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_load;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;
   always_comb begin
      f_y = a;
      case (op)
         3'd0: f_y = a & b;
         3'd1: f_y = a | b;
         3'd2: f_y = a ^ b;
         3'd3: f_y = ~(a ^ b);
         3'd4: f_y = ~(a & b);
         3'd5: f_y = ~(a | b);
         3'd6: f_y = ~a;
         default: f_y = a;
      endcase
   end
   always_comb begin
      pc = '0;
      for (int i = 0; i < WIDTH; i++) pc = pc + MW'(s1_x[i]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_y     <= '0;
         s1_x     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_y <= f_y;
            s1_x <= ~(a ^ b);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         y         <= '0;
         match_cnt <= '0;
         all_eq    <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            y         <= s1_y;
            match_cnt <= pc;
            all_eq    <= pc == MW'(WIDTH);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) eq_count <= '0;
      else if (clr) eq_count <= '0;
      else if (s2_valid && out_ready && all_eq && eq_count != '1) eq_count <= eq_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_logic_pipe_xnor_cmp.sv
// tb_logic_pipe_xnor_cmp: queue-based model bench with directed vectors for logic_pipe_xnor_cmp
module tb_logic_pipe_xnor_cmp;
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, clr = 0;
   logic [7:0] a = 0, b = 0;
   logic [2:0] op = 0;
   logic in_ready, out_valid, all_eq, in_ready2, out_valid2, all_eq2;
   logic [7:0] y, y2;
   logic [3:0] mc, mc2;
   logic [15:0] eq_count;
   logic [1:0] eq_count2;
   typedef struct {logic [7:0] y; int mc; bit eq; int t;} item_t;
   item_t q[$];
   logic [7:0] log_y[$];
   int log_mc[$];
   bit log_eq[$];
   int cyc = 0, checks = 0, failures = 0, exp_cnt = 0, exp_cnt2 = 0;

   logic_pipe_xnor_cmp dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .y(y),
      .match_cnt(mc), .all_eq(all_eq), .eq_count(eq_count), .clr(clr));
   logic_pipe_xnor_cmp #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_ready(in_ready2), .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
      .y(y2), .match_cnt(mc2), .all_eq(all_eq2), .eq_count(eq_count2), .clr(clr));

   always #5 clk = ~clk;

   function automatic logic [7:0] f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
      case (o)
         0: return x & z;
         1: return x | z;
         2: return x ^ z;
         3: return ~(x ^ z);
         4: return ~(x & z);
         5: return ~(x | z);
         6: return ~x;
         default: return x;
      endcase
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", n, act, exp, cyc);
      end
   endtask

   function automatic bit exp_ov();
      return q.size() > 0 && (cyc - q[0].t) >= 2;
   endfunction

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         exp_cnt = 0;
         exp_cnt2 = 0;
      end else begin
         bit ov, ir;
         ov = exp_ov();
         ir = q.size() < 2 || out_ready;
         if (ov && out_ready) begin
            item_t it;
            it = q.pop_front();
            log_y.push_back(y);
            log_mc.push_back(int'(mc));
            log_eq.push_back(all_eq);
            if (!clr && it.eq) begin
               if (exp_cnt < 65535) exp_cnt++;
               if (exp_cnt2 < 3) exp_cnt2++;
            end
         end
         if (clr) begin
            exp_cnt = 0;
            exp_cnt2 = 0;
         end
         if (in_valid && ir) begin
            item_t n;
            n.y = f(op, a, b);
            n.mc = $countones(~(a ^ b));
            n.eq = (a == b);
            n.t = cyc;
            q.push_back(n);
         end
      end
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_y", y, 0);
         chk("rst_match_cnt", mc, 0);
         chk("rst_all_eq", all_eq, 0);
         chk("rst_eq_count", eq_count, 0);
      end else begin
         chk("out_valid", out_valid, exp_ov());
         chk("in_ready", in_ready, q.size() < 2 || out_ready);
         chk("out_valid2", out_valid2, exp_ov());
         chk("in_ready2", in_ready2, q.size() < 2 || out_ready);
         if (exp_ov()) begin
            chk("y", y, q[0].y);
            chk("match_cnt", mc, q[0].mc);
            chk("all_eq", all_eq, q[0].eq);
            chk("y2", y2, q[0].y);
            chk("match_cnt2", mc2, q[0].mc);
            chk("all_eq2", all_eq2, q[0].eq);
         end
         chk("eq_count", eq_count, exp_cnt);
         chk("eq_count2", eq_count2, exp_cnt2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
      int k;
      in_valid = 1;
      op = o;
      a = x;
      b = z;
      for (k = 0; k < 50 && !in_ready; k++) tick();
      if (k == 50) chk("in_ready_timeout", 0, 1);
      tick();
   endtask

   task automatic drain();
      in_valid = 0;
      repeat (4) tick();
   endtask

   logic [7:0] sweep [8] = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h5A, 8'hA5};
   int base;

   initial begin
      repeat (2) tick();
      rst_n = 1;
      #1;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_y", y, 0);
      chk("idle_eq_count", eq_count, 0);
      out_ready = 1;
      // op sweep, back to back
      for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h0F);
      drain();
      chk("sweep_count", log_y.size(), 8);
      for (int i = 0; i < 8 && i < log_y.size(); i++) begin
         chk($sformatf("sweep_y%0d", i), log_y[i], sweep[i]);
         chk($sformatf("sweep_mc%0d", i), log_mc[i], 4);
         chk($sformatf("sweep_eq%0d", i), log_eq[i], 0);
      end
      // latency
      send(3'd3, 8'hFF, 8'h00);
      in_valid = 0;
      chk("lat_1cycle_ov", out_valid, 0);
      tick();
      chk("lat_2cycle_ov", out_valid, 1);
      chk("lat_y", y, 8'h00);
      chk("lat_mc", mc, 0);
      drain();
      // stream of 6
      base = log_y.size();
      for (int i = 0; i < 6; i++) send(3'd2, 8'(i * 17), 8'h33);
      drain();
      chk("stream_count", log_y.size() - base, 6);
      // backpressure
      base = log_y.size();
      out_ready = 0;
      send(3'd2, 8'h12, 8'h34);
      send(3'd0, 8'hF0, 8'hF0);
      in_valid = 1;
      op = 3'd1;
      a = 8'h01;
      b = 8'h02;
      repeat (5) begin
         chk("bp_in_ready", in_ready, 0);
         chk("bp_y_hold", y, 8'h26);
         tick();
         a = a + 8'h40;
      end
      a = 8'h01;
      out_ready = 1;
      tick();
      drain();
      chk("bp_count", log_y.size() - base, 3);
      if (log_y.size() - base == 3) begin
         chk("bp_y0", log_y[base], 8'h26);
         chk("bp_y1", log_y[base+1], 8'hF0);
         chk("bp_y2", log_y[base+2], 8'h03);
      end
      // equality counting
      clr = 1;
      tick();
      clr = 0;
      for (int i = 0; i < 3; i++) send(3'd3, 8'h3C, 8'h3C);
      drain();
      chk("eq3_count", eq_count, 3);
      chk("eq3_mc", log_mc[log_mc.size()-1], 8);
      chk("eq3_all_eq", log_eq[log_eq.size()-1], 1);
      send(3'd3, 8'h3C, 8'h3C);
      in_valid = 0;
      tick();
      clr = 1;
      tick();
      clr = 0;
      chk("clr_wins", eq_count, 0);
      drain();
      // saturation on the 2-bit counter
      for (int i = 0; i < 5; i++) send(3'd7, 8'h81, 8'h81);
      drain();
      chk("sat_count2", eq_count2, 3);
      chk("sat_count16", eq_count, 5);
      out_ready = 0;
      send(3'd7, 8'h42, 8'h42);
      in_valid = 0;
      repeat (5) tick();
      out_ready = 1;
      drain();
      chk("held_once", eq_count, 6);
      // asynchronous reset mid-stream
      send(3'd0, 8'h11, 8'h22);
      send(3'd0, 8'h33, 8'h44);
      chk("pre_rst_ov", out_valid, 1);
      #2;
      rst_n = 0;
      #1;
      chk("async_rst_ov", out_valid, 0);
      chk("async_rst_eq_count", eq_count, 0);
      in_valid = 0;
      repeat (2) tick();
      rst_n = 1;
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
